// File: rtl/rng_pkg.sv
// Shared constants and reader FSM encoding for the random-bit storage consumer.
`timescale 1ns/1ps
package rng_pkg;
  localparam int CHUNK_BITS   = 16;
  localparam int WORD_BITS    = 32;
  localparam int DEFAULT_BITS = 256;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOW  = 2'd1,
    ST_HIGH = 2'd2,
    ST_PUSH = 2'd3
  } rd_state_e;
endpackage

// File: rtl/rng_word_fifo.sv
// Synchronous first-word-fall-through FIFO; dout shows the head word whenever not empty.
`timescale 1ns/1ps
module rng_word_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic [WIDTH-1:0]         din_i,
  output logic [WIDTH-1:0]         dout_o,
  output logic [$clog2(DEPTH):0]   level_o,
  output logic                     full_o,
  output logic                     empty_o
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [LW-1:0]    level_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (push_i) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop_i)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push_i, pop_i})
        2'b10:   level_q <= level_q + 1'b1;
        2'b01:   level_q <= level_q - 1'b1;
        default: level_q <= level_q;
      endcase
    end
  end

  // Storage array carries no reset; dout is forced to zero while empty instead.
  always_ff @(posedge clk_i) begin
    if (push_i) mem_q[wr_ptr_q] <= din_i;
  end

  assign empty_o = (level_q == '0);
  assign full_o  = (level_q == LW'(DEPTH));
  assign level_o = level_q;
  assign dout_o  = empty_o ? '0 : mem_q[rd_ptr_q];
endmodule

// File: rtl/rng_word_reader.sv
// Pulls 16-bit chunks from the random-bit storage, pairs them into 32-bit words
// and buffers the words for the host behind a valid/ready handshake.
`timescale 1ns/1ps
module rng_word_reader
  import rng_pkg::*;
#(
  parameter int BITS       = DEFAULT_BITS,
  parameter int CHUNK      = CHUNK_BITS,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          i_clock,
  input  logic                          i_rst,
  input  logic                          i_enb,
  input  logic                          i_bitValid,
  input  logic [WORD_BITS-1:0]          i_read,
  output logic                          o_read16,
  // Host handshake: o_data/o_valid hold steady until the cycle where
  // o_valid && i_ready, at which edge the head word is consumed.
  output logic [WORD_BITS-1:0]          o_data,
  output logic                          o_valid,
  input  logic                          i_ready,
  output logic [$clog2(FIFO_DEPTH):0]   o_level,
  output logic [$clog2(BITS):0]         o_avail,
  output logic [1:0]                    o_state
);
  localparam int AW = $clog2(BITS) + 1;
  localparam int SW = AW + 1;
  localparam int LW = $clog2(FIFO_DEPTH) + 1;

  rd_state_e      state_q;
  logic [AW-1:0]  avail_q, avail_d;
  logic [SW-1:0]  avail_sum;
  logic [CHUNK-1:0] lo_q, hi_q;
  logic           strobe_prev_q;
  logic           have_chunk;
  logic           read16;
  logic           push;
  logic           pop;
  logic           fifo_full;
  logic           fifo_empty;
  logic           slot_after_push;
  logic [LW-1:0]  level;
  logic           unused_read_hi;

  assign unused_read_hi = ^i_read[WORD_BITS-1:CHUNK];

  assign have_chunk = (avail_q >= AW'(CHUNK));
  // Strobe only from registered state; the HIGH gap gives storage a cycle to advance.
  assign read16 = have_chunk &&
                  ((state_q == ST_LOW) || ((state_q == ST_HIGH) && !strobe_prev_q));
  assign push = (state_q == ST_PUSH);
  assign pop  = o_valid && i_ready;
  assign slot_after_push = (level < LW'(FIFO_DEPTH - 1)) || pop;

  always_comb begin
    avail_sum = {1'b0, avail_q} + {{AW{1'b0}}, i_bitValid};
    if (read16) avail_sum = avail_sum - SW'(CHUNK);
    avail_d = '0;
    if (i_enb) avail_d = (avail_sum > SW'(BITS - 1)) ? AW'(BITS - 1) : avail_sum[AW-1:0];
  end

  always_ff @(posedge i_clock or posedge i_rst) begin
    if (i_rst) avail_q <= '0;
    else       avail_q <= avail_d;
  end

  always_ff @(posedge i_clock or posedge i_rst) begin
    if (i_rst) begin
      state_q       <= ST_IDLE;
      lo_q          <= '0;
      hi_q          <= '0;
      strobe_prev_q <= 1'b0;
    end else begin
      strobe_prev_q <= read16;
      if (!i_enb) begin
        state_q <= ST_IDLE;
      end else begin
        case (state_q)
          ST_IDLE: if (!fifo_full) state_q <= ST_LOW;
          ST_LOW: begin
            if (read16) begin
              lo_q    <= i_read[CHUNK-1:0];
              state_q <= ST_HIGH;
            end
          end
          ST_HIGH: begin
            if (read16) begin
              hi_q    <= i_read[CHUNK-1:0];
              state_q <= ST_PUSH;
            end
          end
          ST_PUSH: state_q <= slot_after_push ? ST_LOW : ST_IDLE;
          default: state_q <= ST_IDLE;
        endcase
      end
    end
  end

  rng_word_fifo #(
    .WIDTH (WORD_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (i_clock),
    .rst_i   (i_rst),
    .push_i  (push),
    .pop_i   (pop),
    .din_i   ({hi_q, lo_q}),
    .dout_o  (o_data),
    .level_o (level),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign o_valid  = !fifo_empty;
  assign o_level  = level;
  assign o_avail  = avail_q;
  assign o_read16 = read16;
  assign o_state  = state_q;
endmodule

// File: tb/tb_rng_word_reader.sv
// Directed bench for rng_word_reader with a behavioural chunk-storage model.
`timescale 1ns/1ps
module tb_rng_word_reader;
  logic        i_clock = 1'b0;
  logic        i_rst;
  logic        i_enb;
  logic        i_bitValid;
  logic [31:0] i_read;
  logic        o_read16;
  logic [31:0] o_data;
  logic        o_valid;
  logic        i_ready;
  logic [2:0]  o_level;
  logic [8:0]  o_avail;
  logic [1:0]  o_state;

  int checks = 0;
  int failures = 0;
  int read16_cnt = 0;
  int rd_idx = 0;
  logic [15:0] chunks [64];
  logic prev_strobe = 1'b0;

  rng_word_reader dut (
    .i_clock    (i_clock),
    .i_rst      (i_rst),
    .i_enb      (i_enb),
    .i_bitValid (i_bitValid),
    .i_read     (i_read),
    .o_read16   (o_read16),
    .o_data     (o_data),
    .o_valid    (o_valid),
    .i_ready    (i_ready),
    .o_level    (o_level),
    .o_avail    (o_avail),
    .o_state    (o_state)
  );

  // clock / reset
  always #5 i_clock = ~i_clock;

  // storage model: oldest chunk on [15:0], discarded at a strobed edge
  assign i_read = {16'h0000, chunks[rd_idx % 64]};
  always @(posedge i_clock) begin
    if (o_read16) begin
      rd_idx     <= rd_idx + 1;
      read16_cnt <= read16_cnt + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge i_clock);
    #1;
  endtask

  // protocol monitor: no adjacent strobes, no push into a full FIFO, valid tracks level
  always @(negedge i_clock) begin
    if (!i_rst) begin
      check("adjacent_strobe", {31'b0, o_read16 && prev_strobe}, 32'd0);
      check("push_on_full", {31'b0, (o_state == 2'd3) && (o_level == 3'd4)}, 32'd0);
      check("valid_vs_level", {31'b0, o_valid}, {31'b0, o_level != 3'd0});
      prev_strobe = o_read16;
    end
  end

  initial begin
    int cyc;
    int base;
    int strobe_k;
    logic [8:0] avail_at;
    logic [8:0] avail_after;

    for (int i = 0; i < 64; i++) chunks[i] = 16'h1000 + 16'(i);
    chunks[0] = 16'hA5A5;
    chunks[1] = 16'h3C3C;

    i_rst = 1'b1; i_enb = 1'b0; i_bitValid = 1'b0; i_ready = 1'b0;
    tick(); tick();
    check("rst_read16", {31'b0, o_read16}, 32'd0);
    check("rst_valid",  {31'b0, o_valid}, 32'd0);
    check("rst_data",   o_data, 32'd0);
    check("rst_level",  {29'b0, o_level}, 32'd0);
    check("rst_avail",  {23'b0, o_avail}, 32'd0);
    i_rst = 1'b0;
    tick();

    // first word: two strobes, valid 34 edges after enable
    i_enb = 1'b1; i_bitValid = 1'b1;
    cyc = 0;
    while (!o_valid && cyc < 200) begin tick(); cyc++; end
    check("first_word_latency", cyc, 34);
    check("first_word_strobes", read16_cnt, 2);
    check("first_word_data", o_data, 32'h3C3CA5A5);
    check("first_word_level", {29'b0, o_level}, 32'd1);

    // fill with no host reads, avail saturates
    repeat (366) tick();
    check("full_level", {29'b0, o_level}, 32'd4);
    check("full_strobes", read16_cnt, 8);
    check("full_avail_sat", {23'b0, o_avail}, 32'd255);
    check("full_state_idle", {30'b0, o_state}, 32'd0);
    check("full_head", o_data, 32'h3C3CA5A5);

    // single pop, reader refills
    i_ready = 1'b1;
    base = read16_cnt;
    tick();
    i_ready = 1'b0;
    check("pop_level", {29'b0, o_level}, 32'd3);
    check("pop_head", o_data, 32'h10031002);
    repeat (5) tick();
    check("refill_level", {29'b0, o_level}, 32'd4);
    check("refill_strobes", read16_cnt - base, 2);
    check("refill_avail", {23'b0, o_avail}, 32'd227);

    // drain with storage disabled
    i_enb = 1'b0; i_bitValid = 1'b0; i_ready = 1'b1;
    repeat (6) tick();
    check("drain_level", {29'b0, o_level}, 32'd0);
    check("drain_avail", {23'b0, o_avail}, 32'd0);

    // sparse bits: one every 3 cycles
    i_enb = 1'b1;
    strobe_k = -1; avail_at = '0; avail_after = '0;
    for (int k = 0; k < 50; k++) begin
      i_bitValid = (k % 3 == 0);
      if (o_read16 && strobe_k < 0) begin
        strobe_k = k;
        avail_at = o_avail;
      end
      tick();
      if (k == strobe_k) avail_after = o_avail;
    end
    check("sparse_strobe_cycle", strobe_k, 46);
    check("sparse_avail_at", {23'b0, avail_at}, 32'd16);
    check("sparse_avail_after", {23'b0, avail_after}, 32'd0);
    check("sparse_state_high", {30'b0, o_state}, 32'd2);

    // drop enable while holding a low chunk
    i_enb = 1'b0; i_bitValid = 1'b0;
    tick();
    check("drop_avail", {23'b0, o_avail}, 32'd0);
    check("drop_state", {30'b0, o_state}, 32'd0);
    repeat (3) tick();
    check("drop_no_push", {31'b0, o_valid}, 32'd0);

    // re-enable: word built from fresh chunks 11 and 12
    i_ready = 1'b0; i_enb = 1'b1; i_bitValid = 1'b1;
    cyc = 0;
    while (!o_valid && cyc < 200) begin tick(); cyc++; end
    check("reen_latency", cyc, 34);
    check("reen_data", o_data, 32'h100C100B);
    check("reen_level", {29'b0, o_level}, 32'd1);

    // async reset in the middle of a PUSH with two words held
    cyc = 0;
    while (!(o_state == 2'd3 && o_level == 3'd2) && cyc < 200) begin tick(); cyc++; end
    check("push_l2_reached", cyc, 63);
    #2 i_rst = 1'b1;
    #1;
    check("arst_valid",  {31'b0, o_valid}, 32'd0);
    check("arst_level",  {29'b0, o_level}, 32'd0);
    check("arst_avail",  {23'b0, o_avail}, 32'd0);
    check("arst_read16", {31'b0, o_read16}, 32'd0);
    check("arst_data",   o_data, 32'd0);
    #20;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
